// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the JTAG TAP controller: state encoding, opcodes,
// Capture-IR pattern and the instruction decoder.
// Optional feature macro: JTAG_TAP_USERCODE_EN (enables the USERCODE instruction).
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        ST_TLR    = 4'd0,
        ST_RTI    = 4'd1,
        ST_SEL_DR = 4'd2,
        ST_CAP_DR = 4'd3,
        ST_SH_DR  = 4'd4,
        ST_EX1_DR = 4'd5,
        ST_PAU_DR = 4'd6,
        ST_EX2_DR = 4'd7,
        ST_UPD_DR = 4'd8,
        ST_SEL_IR = 4'd9,
        ST_CAP_IR = 4'd10,
        ST_SH_IR  = 4'd11,
        ST_EX1_IR = 4'd12,
        ST_PAU_IR = 4'd13,
        ST_EX2_IR = 4'd14,
        ST_UPD_IR = 4'd15
    } tap_state_e;

    // Which data register sits between tdi and tdo for the current instruction
    typedef enum logic [1:0] {
        SEL_BYPASS   = 2'd0,
        SEL_IDCODE   = 2'd1,
        SEL_DEBUG    = 2'd2,
        SEL_USERCODE = 2'd3
    } dr_sel_e;

    localparam logic [3:0] OP_BYPASS   = 4'b1111;
    localparam logic [3:0] OP_IDCODE   = 4'b0001;
    localparam logic [3:0] OP_DEBUG    = 4'b1000;
    localparam logic [3:0] OP_USERCODE = 4'b0010;
    localparam logic [3:0] IR_CAPTURE  = 4'b0101;

    // Unknown opcodes fall back to BYPASS so a scan chain never breaks
    function automatic dr_sel_e decode_ir(input logic [3:0] ir);
        dr_sel_e sel;
        case (ir)
            OP_IDCODE:   sel = SEL_IDCODE;
            OP_DEBUG:    sel = SEL_DEBUG;
`ifdef JTAG_TAP_USERCODE_EN
            OP_USERCODE: sel = SEL_USERCODE;
`endif
            default:     sel = SEL_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller state machine, advanced by tms on tck rise.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       tck,
    input  logic       rst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e r_state;
    tap_state_e w_next;

    // State register, async reset to Test-Logic-Reset
    always_ff @(posedge tck or posedge rst) begin
        if (rst) r_state <= ST_TLR;
        else     r_state <= w_next;
    end

    // Standard TAP transition table
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:    w_next = tms ? ST_TLR    : ST_RTI;
            ST_RTI:    w_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: w_next = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: w_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  w_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: w_next = tms ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: w_next = tms ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: w_next = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: w_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: w_next = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: w_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  w_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: w_next = tms ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: w_next = tms ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: w_next = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: w_next = tms ? ST_SEL_DR : ST_RTI;
            default:   w_next = ST_TLR;
        endcase
    end

    assign state = r_state;

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP: 4-bit IR, BYPASS / IDCODE / DEBUG data registers, falling-edge tdo.
// Optional feature macro: JTAG_TAP_USERCODE_EN (USERCODE captures USERCODE_VALUE).
module jtag_tap
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE   = 32'h149511C3,
    parameter logic [31:0] USERCODE_VALUE = 32'h00000000
) (
    input  logic tck,
    input  logic rst,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_oe,
    output logic debug_select,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic debug_tdi,
    input  logic debug_tdo
);

    tap_state_e  w_state;
    logic [3:0]  r_ir;
    logic [3:0]  r_ir_sr;
    logic [3:0]  w_ir_eff;
    dr_sel_e     w_sel;
    logic        w_dr32_sel;
    logic [31:0] w_dr32_cap;
    logic [31:0] r_dr32;
    logic        r_bypass;
    logic        w_tdo_next;
    logic        r_tdo;
    logic        r_tdo_oe;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .rst   (rst),
        .tms   (tms),
        .state (w_state)
    );

    // Test-Logic-Reset forces IDCODE immediately, not one tck after entry
    assign w_ir_eff = (w_state == ST_TLR) ? OP_IDCODE : r_ir;
    assign w_sel    = decode_ir(w_ir_eff);

`ifdef JTAG_TAP_USERCODE_EN
    assign w_dr32_sel = (w_sel == SEL_IDCODE) || (w_sel == SEL_USERCODE);
    assign w_dr32_cap = (w_sel == SEL_USERCODE) ? USERCODE_VALUE : IDCODE_VALUE;
`else
    logic w_unused_usercode;
    assign w_unused_usercode = ^USERCODE_VALUE;
    assign w_dr32_sel = (w_sel == SEL_IDCODE);
    assign w_dr32_cap = IDCODE_VALUE;
`endif

    // IR shift register: fixed pattern on capture, LSB-first shift toward tdo
    always_ff @(posedge tck or posedge rst) begin
        if (rst)                      r_ir_sr <= IR_CAPTURE;
        else if (w_state == ST_CAP_IR) r_ir_sr <= IR_CAPTURE;
        else if (w_state == ST_SH_IR)  r_ir_sr <= {tdi, r_ir_sr[3:1]};
    end

    // Active instruction: only Update-IR or Test-Logic-Reset may change it
    always_ff @(posedge tck or posedge rst) begin
        if (rst)                      r_ir <= OP_IDCODE;
        else if (w_state == ST_TLR)    r_ir <= OP_IDCODE;
        else if (w_state == ST_UPD_IR) r_ir <= r_ir_sr;
    end

    // 32-bit IDCODE/USERCODE register; holds when another DR is selected
    always_ff @(posedge tck or posedge rst) begin
        if (rst) r_dr32 <= '0;
        else if (w_dr32_sel) begin
            if (w_state == ST_CAP_DR)     r_dr32 <= w_dr32_cap;
            else if (w_state == ST_SH_DR) r_dr32 <= {tdi, r_dr32[31:1]};
        end
    end

    // 1-bit bypass register
    always_ff @(posedge tck or posedge rst) begin
        if (rst) r_bypass <= 1'b0;
        else if (w_sel == SEL_BYPASS) begin
            if (w_state == ST_CAP_DR)     r_bypass <= 1'b0;
            else if (w_state == ST_SH_DR) r_bypass <= tdi;
        end
    end

    // tdo source select; zero outside the shift states
    always_comb begin
        w_tdo_next = 1'b0;
        if (w_state == ST_SH_IR) begin
            w_tdo_next = r_ir_sr[0];
        end else if (w_state == ST_SH_DR) begin
            case (w_sel)
                SEL_IDCODE, SEL_USERCODE: w_tdo_next = r_dr32[0];
                SEL_DEBUG:                w_tdo_next = debug_tdo;
                default:                  w_tdo_next = r_bypass;
            endcase
        end
    end

    // tdo and its enable change on the falling edge so they are stable at the next rise
    always_ff @(negedge tck or posedge rst) begin
        if (rst) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_next;
            r_tdo_oe <= (w_state == ST_SH_IR) || (w_state == ST_SH_DR);
        end
    end

    assign tdo          = r_tdo;
    assign tdo_oe       = r_tdo_oe;
    assign debug_select = (w_sel == SEL_DEBUG);
    assign capture_dr   = (w_state == ST_CAP_DR);
    assign shift_dr     = (w_state == ST_SH_DR);
    assign update_dr    = (w_state == ST_UPD_DR);
    assign debug_tdi    = tdi;

endmodule

// File: doc/jtag_tap.md
JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 SHALL have parameter IDCODE_VALUE, default 32'h149511C3, 32-bit value loaded by Capture-DR under IDCODE; bit 0 SHALL be 1.
REQ-002 SHALL have parameter USERCODE_VALUE, default 32'h00000000, value loaded by Capture-DR under USERCODE (see Configuration).
REQ-003 tck  input  1  sole clock (JTAG test clock); rising edge for state and shift registers, falling edge for tdo only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tms  input  1  test mode select, sampled on tck rising edge.
REQ-006 tdi  input  1  serial data in, sampled on tck rising edge.
REQ-007 tdo  output  1  serial data out, updated on tck falling edge.
REQ-008 tdo_oe  output  1  high while in Shift-IR or Shift-DR, registered on tck falling edge.
REQ-009 debug_select  output  1  high while the current instruction is DEBUG.
REQ-010 capture_dr, shift_dr, update_dr  output  1 each  high while the TAP is in the corresponding DR state.
REQ-011 debug_tdi  output  1  equals tdi, passed through for the external debug DR.
REQ-012 debug_tdo  input  1  serial output of the external debug DR.

Function
REQ-013 SHALL implement the 16-state IEEE 1149.1 TAP FSM; next state is chosen by tms on each tck rising edge.
REQ-014 Five consecutive tms=1 clocks SHALL reach Test-Logic-Reset from any state; tms=0 from there SHALL enter Run-Test/Idle.
REQ-015 The IR SHALL be 4 bits; opcodes: BYPASS=4'b1111, IDCODE=4'b0001, DEBUG=4'b1000, USERCODE=4'b0010; any other opcode SHALL decode as BYPASS.
REQ-016 Capture-IR SHALL load 4'b0101 into the IR shift register; Shift-IR SHALL shift LSB-first from tdi towards tdo.
REQ-017 Update-IR SHALL copy the IR shift register into the active instruction; the instruction SHALL NOT change in any other state.
REQ-018 IDCODE: Capture-DR SHALL load IDCODE_VALUE into a 32-bit DR, shifted LSB-first during Shift-DR.
REQ-019 BYPASS: Capture-DR SHALL load 0 into a 1-bit DR, giving exactly one tck of tdi-to-tdo delay in Shift-DR.
REQ-020 DEBUG: tdo SHALL take debug_tdo during Shift-DR; the internal DRs SHALL hold their values.
REQ-021 Outside Shift-IR/Shift-DR, tdo SHALL be 0 and tdo_oe 0.
REQ-022 Exit1/Pause/Exit2 SHALL hold shift register contents; Exit2 with tms=0 SHALL resume shifting without recapture.
REQ-023 Entering Test-Logic-Reset by tms SHALL load IDCODE as the active instruction.

Reset
REQ-024 rst=1 SHALL asynchronously force: state Test-Logic-Reset, instruction IDCODE, IR shift register 4'b0101, DRs 0, tdo 0, tdo_oe 0, debug_select 0, capture_dr/shift_dr/update_dr 0.
REQ-025 rst asserted mid-shift SHALL discard the partial shift; no Update SHALL occur.

Configuration
REQ-026 Macro JTAG_TAP_USERCODE_EN defined: USERCODE SHALL capture USERCODE_VALUE into the 32-bit DR.
REQ-027 Macro undefined: opcode 4'b0010 SHALL decode as BYPASS and USERCODE_VALUE SHALL be unused.

Structure
REQ-028 A shared package jtag_tap_pkg SHALL hold the TAP state enum, the opcode constants, and the Capture-IR constant 4'b0101.
REQ-029 The FSM SHALL be a sub-module, jtag_tap_fsm (inputs tck, rst, tms; output state); the data path SHALL stay in jtag_tap.

Verification
REQ-030 rst pulse, then 5x tms=1, then tms=0 -> state Run-Test/Idle, instruction IDCODE, tdo_oe=0.
REQ-031 From Run-Test/Idle: tms 1,0,0, shift 32 bits with tdi=0, last bit tms=1 -> tdo sequence LSB-first = 32'h149511C3.
REQ-032 Load IR 4'b1111, shift 8'hA5 in Shift-DR -> tdo returns 8'hA5 delayed one tck, first bit 0.
REQ-033 Load IR 4'b1000 while capturing IR -> first 4 tdo bits 1,0,1,0 (4'b0101 LSB-first), then debug_select=1; DR scan shows capture_dr, shift_dr and update_dr high in their states and tdo equal to debug_tdo.
REQ-034 rst asserted during the 10th bit of an IDCODE Shift-DR -> immediate Test-Logic-Reset, tdo=0, tdo_oe=0, no update_dr.
REQ-035 With JTAG_TAP_USERCODE_EN and USERCODE_VALUE=32'hCAFE0001, load IR 4'b0010 and scan DR -> tdo reads 32'hCAFE0001; without the macro -> one-bit bypass behaviour.
